alu_share_ctrl: RTL and testbench

- Sequencer and arbiter that shares the single 16-bit combinational ALU (ADD, or load-upper: result = {inB[7:0], 8'h00}) between two requesters in the CPU, e.g. fetch/PC-update and execute.
- Grants requests round-robin and drives the ALU input ports from registered operands.
- Runs the two-pass LI16 macro-op (load-upper then add low byte).
- Returns the registered result through a valid/ready response channel.

---
 rtl/alu_share_pkg.sv | 26 ++
 rtl/rr_arb2.sv | 41 ++++
 rtl/alu_share_ctrl.sv | 133 +++++++++++++
 tb/tb_alu_share_ctrl.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_share_pkg.sv
// Shared definitions for the ALU sharing controller: opcodes, ALU operation codes, FSM states.
package alu_share_pkg;

  // Requester opcodes
  localparam logic [1:0] OP_ADD  = 2'b00;
  localparam logic [1:0] OP_LUI  = 2'b01;
  localparam logic [1:0] OP_LI16 = 2'b10;
  localparam logic [1:0] OP_MOVA = 2'b11;

  // ALU operation select
  localparam logic ALU_ADD = 1'b0;
  localparam logic ALU_LUI = 1'b1;

  typedef enum logic [1:0] {
    StIdle,
    StExec,
    StExec2,
    StResp
  } state_e;

  // LI16 is the only macro-op that needs a second ALU pass.
  function automatic logic is_two_pass(input logic [1:0] op);
    return op == OP_LI16;
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-input round-robin arbiter. On a tie the requester that was not granted last wins.
module rr_arb2 (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic valid0,
  input  logic valid1,
  output logic gnt0,
  output logic gnt1,
  output logic gnt_id
);

  logic last_id_q;

  // Grant selection; at most one grant, and only towards a valid requester.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (en) begin
      if (valid0 && valid1) begin
        gnt0 = last_id_q;
        gnt1 = ~last_id_q;
      end else if (valid0) begin
        gnt0 = 1'b1;
      end else if (valid1) begin
        gnt1 = 1'b1;
      end
    end
    gnt_id = gnt1;
  end

  // Pointer tracks the most recent winner; reset to 1 so requester 0 wins the first tie.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_id_q <= 1'b1;
    end else if (gnt0 || gnt1) begin
      last_id_q <= gnt1;
    end
  end

endmodule

// File: rtl/alu_share_ctrl.sv
// Shares one combinational 16-bit ALU between two requesters: arbitrate, sequence the
// ALU passes (two for LI16), then hold the result on a valid/ready response channel.
module alu_share_ctrl
  import alu_share_pkg::*;
#(
  parameter int unsigned WIDTH        = 16,
  parameter bit          ZERO_FLAG_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [1:0]       req0_op,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [1:0]       req1_op,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_result,
  output logic             rsp_zero,
  output logic [WIDTH-1:0] alu_inA,
  output logic [WIDTH-1:0] alu_inB,
  output logic             alu_operation,
  input  logic [WIDTH-1:0] alu_result,
  output logic             busy
);

  state_e           state_q, state_d;
  logic [1:0]       op_q;
  logic [WIDTH-1:0] a_q, b_q, res_q;
  logic             id_q, zero_q;

  logic arb_en, gnt0, gnt1, gnt_id, hs;

  // Grants only offered in idle and never while reset is asserted.
  assign arb_en = (state_q == StIdle) && !rst;

  rr_arb2 u_arb (
    .clk    (clk),
    .rst    (rst),
    .en     (arb_en),
    .valid0 (req0_valid),
    .valid1 (req1_valid),
    .gnt0   (gnt0),
    .gnt1   (gnt1),
    .gnt_id (gnt_id)
  );

  assign req0_ready = gnt0;
  assign req1_ready = gnt1;
  assign hs         = gnt0 | gnt1;

  // Next-state and ALU port drive; ports idle at zero/add outside the execute states.
  always_comb begin
    state_d       = state_q;
    alu_inA       = '0;
    alu_inB       = '0;
    alu_operation = ALU_ADD;
    unique case (state_q)
      StIdle: begin
        if (hs) state_d = StExec;
      end
      StExec: begin
        unique case (op_q)
          OP_ADD: begin
            alu_inA = a_q;
            alu_inB = b_q;
          end
          OP_LUI: begin
            alu_operation = ALU_LUI;
            alu_inB       = b_q;
          end
          OP_LI16: begin
            // First pass places the immediate's high byte in the upper half.
            alu_operation = ALU_LUI;
            alu_inB       = {{(WIDTH-8){1'b0}}, b_q[15:8]};
          end
          OP_MOVA: begin
            alu_inA = a_q;
          end
          default: ;
        endcase
        state_d = is_two_pass(op_q) ? StExec2 : StResp;
      end
      StExec2: begin
        alu_inA = res_q;
        alu_inB = {{(WIDTH-8){1'b0}}, b_q[7:0]};
        state_d = StResp;
      end
      StResp: begin
        if (rsp_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // State, operand capture at handshake, result capture after each ALU pass.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      op_q    <= OP_ADD;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      id_q    <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (hs) begin
        id_q <= gnt_id;
        op_q <= gnt_id ? req1_op : req0_op;
        a_q  <= gnt_id ? req1_a : req0_a;
        b_q  <= gnt_id ? req1_b : req0_b;
      end
      if (state_q == StExec || state_q == StExec2) begin
        res_q  <= alu_result;
        zero_q <= (alu_result == '0);
      end
    end
  end

  assign rsp_valid  = (state_q == StResp);
  assign busy       = (state_q != StIdle);
  assign rsp_result = res_q;
  assign rsp_id     = id_q;
  assign rsp_zero   = ZERO_FLAG_EN ? zero_q : 1'b0;

endmodule

// File: tb/tb_alu_share_ctrl.sv
// Directed bench for alu_share_ctrl with a behavioural model of the shared ALU.
module tb_alu_share_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0_valid, req0_ready;
  logic [1:0]  req0_op;
  logic [15:0] req0_a, req0_b;
  logic        req1_valid, req1_ready;
  logic [1:0]  req1_op;
  logic [15:0] req1_a, req1_b;
  logic        rsp_valid, rsp_ready, rsp_id, rsp_zero;
  logic [15:0] rsp_result;
  logic [15:0] alu_inA, alu_inB, alu_result;
  logic        alu_operation;
  logic        busy;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  // External ALU: add, or load-upper of inB's low byte.
  assign alu_result = alu_operation ? {alu_inB[7:0], 8'h00} : alu_inA + alu_inB;

  alu_share_ctrl #(
    .WIDTH        (16),
    .ZERO_FLAG_EN (1'b1)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .req0_valid    (req0_valid),
    .req0_ready    (req0_ready),
    .req0_op       (req0_op),
    .req0_a        (req0_a),
    .req0_b        (req0_b),
    .req1_valid    (req1_valid),
    .req1_ready    (req1_ready),
    .req1_op       (req1_op),
    .req1_a        (req1_a),
    .req1_b        (req1_b),
    .rsp_valid     (rsp_valid),
    .rsp_ready     (rsp_ready),
    .rsp_id        (rsp_id),
    .rsp_result    (rsp_result),
    .rsp_zero      (rsp_zero),
    .alu_inA       (alu_inA),
    .alu_inB       (alu_inB),
    .alu_operation (alu_operation),
    .alu_result    (alu_result),
    .busy          (busy)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req0_valid = 1'b1; req0_op = 2'b00; req0_a = 16'h0; req0_b = 16'h0;
    req1_valid = 1'b1; req1_op = 2'b00; req1_a = 16'h0; req1_b = 16'h0;
    rsp_ready = 1'b1;
    tick();
    tick();
    n_total++; if (req0_ready !== 1'b0) $display("FAIL rst_ready0: got %b want 0", req0_ready); else n_pass++;
    n_total++; if (req1_ready !== 1'b0) $display("FAIL rst_ready1: got %b want 0", req1_ready); else n_pass++;
    n_total++; if (rsp_valid !== 1'b0) $display("FAIL rst_valid: got %b want 0", rsp_valid); else n_pass++;
    n_total++; if (rsp_result !== 16'h0) $display("FAIL rst_result: got %h want 0000", rsp_result); else n_pass++;
    n_total++; if (rsp_id !== 1'b0) $display("FAIL rst_id: got %b want 0", rsp_id); else n_pass++;
    n_total++; if (rsp_zero !== 1'b0) $display("FAIL rst_zero: got %b want 0", rsp_zero); else n_pass++;
    n_total++; if (busy !== 1'b0) $display("FAIL rst_busy: got %b want 0", busy); else n_pass++;
    n_total++; if ({alu_inA, alu_inB, alu_operation} !== 33'h0)
      $display("FAIL rst_alu: got %h/%h/%b want 0/0/0", alu_inA, alu_inB, alu_operation); else n_pass++;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    rst = 1'b0;
    tick();
  endtask

  task automatic test_add();
    req0_valid = 1'b1; req0_op = 2'b00; req0_a = 16'h1234; req0_b = 16'h0001;
    rsp_ready = 1'b1;
    #1;
    n_total++; if ({req0_ready, req1_ready} !== 2'b10)
      $display("FAIL add_grant: got r0=%b r1=%b want 1/0", req0_ready, req1_ready); else n_pass++;
    tick();  // handshake edge
    req0_valid = 1'b0; req0_a = 16'hDEAD; req0_b = 16'hBEEF;  // must not leak in
    #1;
    n_total++; if (rsp_valid !== 1'b0) $display("FAIL add_exec_valid: got %b want 0", rsp_valid); else n_pass++;
    n_total++; if (busy !== 1'b1) $display("FAIL add_exec_busy: got %b want 1", busy); else n_pass++;
    n_total++; if ({alu_operation, alu_inA, alu_inB} !== {1'b0, 16'h1234, 16'h0001})
      $display("FAIL add_exec_alu: got %b/%h/%h want 0/1234/0001", alu_operation, alu_inA, alu_inB);
    else n_pass++;
    tick();
    n_total++; if (rsp_valid !== 1'b1) $display("FAIL add_latency: got %b want 1", rsp_valid); else n_pass++;
    n_total++; if (rsp_result !== 16'h1235) $display("FAIL add_result: got %h want 1235", rsp_result); else n_pass++;
    n_total++; if (rsp_id !== 1'b0) $display("FAIL add_id: got %b want 0", rsp_id); else n_pass++;
    n_total++; if (rsp_zero !== 1'b0) $display("FAIL add_zero: got %b want 0", rsp_zero); else n_pass++;
    n_total++; if ({alu_inA, alu_inB} !== 32'h0)
      $display("FAIL add_resp_alu: got %h/%h want 0/0", alu_inA, alu_inB); else n_pass++;
    tick();
    n_total++; if ({rsp_valid, busy} !== 2'b00)
      $display("FAIL add_back_idle: got valid=%b busy=%b want 0/0", rsp_valid, busy); else n_pass++;
  endtask

  task automatic test_wrap_zero();
    req1_valid = 1'b1; req1_op = 2'b00; req1_a = 16'hFFFF; req1_b = 16'h0001;
    #1;
    n_total++; if ({req0_ready, req1_ready} !== 2'b01)
      $display("FAIL wrap_grant: got r0=%b r1=%b want 0/1", req0_ready, req1_ready); else n_pass++;
    tick();
    req1_valid = 1'b0;
    tick();
    n_total++; if (rsp_valid !== 1'b1) $display("FAIL wrap_valid: got %b want 1", rsp_valid); else n_pass++;
    n_total++; if (rsp_result !== 16'h0000) $display("FAIL wrap_result: got %h want 0000", rsp_result); else n_pass++;
    n_total++; if (rsp_zero !== 1'b1) $display("FAIL wrap_zero: got %b want 1", rsp_zero); else n_pass++;
    n_total++; if (rsp_id !== 1'b1) $display("FAIL wrap_id: got %b want 1", rsp_id); else n_pass++;
    tick();
  endtask

  task automatic test_li16();
    req0_valid = 1'b1; req0_op = 2'b10; req0_a = 16'h1111; req0_b = 16'hBEEF;
    tick();
    req0_valid = 1'b0;
    #1;
    n_total++; if ({alu_operation, alu_inB} !== {1'b1, 16'h00BE})
      $display("FAIL li16_pass1: got op=%b inB=%h want 1/00BE", alu_operation, alu_inB); else n_pass++;
    n_total++; if (rsp_valid !== 1'b0) $display("FAIL li16_exec_valid: got %b want 0", rsp_valid); else n_pass++;
    tick();
    n_total++; if ({alu_operation, alu_inA, alu_inB} !== {1'b0, 16'hBE00, 16'h00EF})
      $display("FAIL li16_pass2: got %b/%h/%h want 0/BE00/00EF", alu_operation, alu_inA, alu_inB);
    else n_pass++;
    n_total++; if (rsp_valid !== 1'b0) $display("FAIL li16_exec2_valid: got %b want 0", rsp_valid); else n_pass++;
    tick();
    n_total++; if (rsp_valid !== 1'b1) $display("FAIL li16_latency: got %b want 1", rsp_valid); else n_pass++;
    n_total++; if (rsp_result !== 16'hBEEF) $display("FAIL li16_result: got %h want BEEF", rsp_result); else n_pass++;
    n_total++; if ({rsp_id, rsp_zero} !== 2'b00)
      $display("FAIL li16_id_zero: got id=%b zero=%b want 0/0", rsp_id, rsp_zero); else n_pass++;
    tick();
  endtask

  task automatic test_mova();
    req1_valid = 1'b1; req1_op = 2'b11; req1_a = 16'h00A5; req1_b = 16'hFFFF;
    tick();
    req1_valid = 1'b0;
    #1;
    n_total++; if ({alu_operation, alu_inA, alu_inB} !== {1'b0, 16'h00A5, 16'h0000})
      $display("FAIL mova_alu: got %b/%h/%h want 0/00A5/0000", alu_operation, alu_inA, alu_inB);
    else n_pass++;
    tick();
    n_total++; if ({rsp_valid, rsp_id, rsp_result} !== {1'b1, 1'b1, 16'h00A5})
      $display("FAIL mova_rsp: got v=%b id=%b res=%h want 1/1/00A5", rsp_valid, rsp_id, rsp_result);
    else n_pass++;
    tick();
  endtask

  task automatic test_round_robin();
    logic [15:0] exp_res;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    req0_valid = 1'b1; req0_op = 2'b00; req0_a = 16'h0010; req0_b = 16'h0001;
    req1_valid = 1'b1; req1_op = 2'b00; req1_a = 16'h0020; req1_b = 16'h0002;
    rsp_ready = 1'b1;
    #1;
    for (int i = 0; i < 4; i++) begin
      exp_res = (i % 2 == 0) ? 16'h0011 : 16'h0022;
      n_total++; if ({req0_ready, req1_ready} !== ((i % 2 == 0) ? 2'b10 : 2'b01))
        $display("FAIL rr_grant%0d: got r0=%b r1=%b want %0d", i, req0_ready, req1_ready, i % 2);
      else n_pass++;
      tick();
      n_total++; if ({req0_ready, req1_ready} !== 2'b00)
        $display("FAIL rr_exec_ready%0d: got r0=%b r1=%b want 0/0", i, req0_ready, req1_ready);
      else n_pass++;
      tick();
      n_total++; if ({rsp_valid, rsp_id, rsp_result} !== {1'b1, i[0], exp_res})
        $display("FAIL rr_rsp%0d: got v=%b id=%b res=%h want 1/%0d/%h", i, rsp_valid, rsp_id,
                 rsp_result, i % 2, exp_res);
      else n_pass++;
      n_total++; if ({req0_ready, req1_ready} !== 2'b00)
        $display("FAIL rr_resp_ready%0d: got r0=%b r1=%b want 0/0", i, req0_ready, req1_ready);
      else n_pass++;
      tick();
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    tick();
  endtask

  task automatic test_backpressure();
    req0_valid = 1'b1; req0_op = 2'b01; req0_a = 16'h9999; req0_b = 16'h0042;
    rsp_ready = 1'b0;
    tick();
    req0_valid = 1'b0;
    req1_valid = 1'b1; req1_op = 2'b00; req1_a = 16'h0001; req1_b = 16'h0001;
    #1;
    n_total++; if ({alu_operation, alu_inB} !== {1'b1, 16'h0042})
      $display("FAIL bp_exec_alu: got op=%b inB=%h want 1/0042", alu_operation, alu_inB); else n_pass++;
    tick();
    for (int i = 0; i < 5; i++) begin
      n_total++; if ({rsp_valid, rsp_result} !== {1'b1, 16'h4200})
        $display("FAIL bp_hold%0d: got v=%b res=%h want 1/4200", i, rsp_valid, rsp_result);
      else n_pass++;
      n_total++; if ({req0_ready, req1_ready} !== 2'b00)
        $display("FAIL bp_ready%0d: got r0=%b r1=%b want 0/0", i, req0_ready, req1_ready);
      else n_pass++;
      tick();
    end
    rsp_ready = 1'b1;
    #1;
    n_total++; if ({rsp_valid, rsp_result} !== {1'b1, 16'h4200})
      $display("FAIL bp_release: got v=%b res=%h want 1/4200", rsp_valid, rsp_result); else n_pass++;
    tick();
    n_total++; if ({busy, rsp_valid, req1_ready} !== 3'b001)
      $display("FAIL bp_idle: got busy=%b v=%b r1=%b want 0/0/1", busy, rsp_valid, req1_ready);
    else n_pass++;
    req1_valid = 1'b0;
    #1;
  endtask

  task automatic test_reset_mid_op();
    // Requester 0 wins last, so without reset a tie would go to requester 1.
    req0_valid = 1'b1; req0_op = 2'b10; req0_a = 16'h0; req0_b = 16'h1234;
    rsp_ready = 1'b1;
    tick();
    req0_valid = 1'b0;
    tick();
    n_total++; if ({busy, alu_inA} !== {1'b1, 16'h1200})
      $display("FAIL mid_exec2: got busy=%b inA=%h want 1/1200", busy, alu_inA); else n_pass++;
    rst = 1'b1;
    req0_valid = 1'b1; req0_op = 2'b00; req0_a = 16'h0005; req0_b = 16'h0003;
    req1_valid = 1'b1; req1_op = 2'b00; req1_a = 16'h0100; req1_b = 16'h0100;
    #1;
    n_total++; if ({req0_ready, req1_ready} !== 2'b00)
      $display("FAIL mid_rst_ready: got r0=%b r1=%b want 0/0", req0_ready, req1_ready); else n_pass++;
    tick();
    rst = 1'b0;
    #1;
    n_total++; if ({rsp_valid, busy, rsp_id, rsp_zero, rsp_result} !== 20'h0)
      $display("FAIL mid_outputs: got v=%b busy=%b id=%b z=%b res=%h want all 0", rsp_valid, busy,
               rsp_id, rsp_zero, rsp_result);
    else n_pass++;
    n_total++; if ({alu_operation, alu_inA, alu_inB} !== 33'h0)
      $display("FAIL mid_alu: got %b/%h/%h want 0/0/0", alu_operation, alu_inA, alu_inB); else n_pass++;
    n_total++; if ({req0_ready, req1_ready} !== 2'b10)
      $display("FAIL mid_regrant: got r0=%b r1=%b want 1/0", req0_ready, req1_ready); else n_pass++;
    tick();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    #1;
    n_total++; if (rsp_valid !== 1'b0) $display("FAIL mid_no_rsp: got %b want 0", rsp_valid); else n_pass++;
    tick();
    n_total++; if ({rsp_valid, rsp_id, rsp_result} !== {1'b1, 1'b0, 16'h0008})
      $display("FAIL mid_after: got v=%b id=%b res=%h want 1/0/0008", rsp_valid, rsp_id, rsp_result);
    else n_pass++;
    tick();
  endtask

  initial begin
    test_reset();
    test_add();
    test_wrap_zero();
    test_li16();
    test_mova();
    test_round_robin();
    test_backpressure();
    test_reset_mid_op();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
